// File: rtl/pwm_pkg.sv
// Shared definitions for the RGB PWM driver and its helpers.
// Channel indices match the bit order of the rgb output and the duty_in fields.
package pwm_pkg;

    localparam int R_DEFAULT = 8;

    localparam int CH_RED   = 0;
    localparam int CH_BLUE  = 1;
    localparam int CH_GREEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        SCALE0,
        SCALE1,
        SCALE2,
        ARMED
    } drv_state_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Tick generator: one tick every dvsr+1 clock cycles.
// Also used by the sequencer's gradient timer.
module pwm_prescaler #(
    parameter int DVSR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DVSR_W-1:0] dvsr,
    output logic              tick
);

    logic [DVSR_W-1:0] tick_cnt;

    // Use >= rather than == so that lowering dvsr below the running count
    // ticks at once, instead of wrapping through the whole counter range.
    assign tick = (tick_cnt >= dvsr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + DVSR_W'(1);
        end
    end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM driver: accepts a duty triple, scales it by brightness,
// and swaps it in only at a period boundary so that no pulse is ever split.
module rgb_pwm_driver
    import pwm_pkg::*;
#(
    parameter int R      = R_DEFAULT,
    parameter int DVSR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic [R-1:0]      brightness,
    input  logic [3*(R+1)-1:0] duty_in,
    input  logic              duty_valid,
    output logic              duty_ready,
    output logic              commit,
    output logic [2:0]        rgb
);

    localparam logic [R:0]   DUTY_MAX = {1'b1, {R{1'b0}}};
    localparam logic [R-1:0] CNT_MAX  = '1;

    drv_state_t state, state_next;

    logic [R:0]     stage  [3];
    logic [R:0]     shadow [3];
    logic [R:0]     active [3];
    logic [R-1:0]   bright_q;
    logic [R-1:0]   pwm_cnt;
    logic           tick;
    logic           boundary;
    logic           accept;

    logic [R:0]     mul_in;
    logic [R:0]     gain;
    logic [2*R:0]   product;
    logic [R:0]     scaled;
    logic [R-1:0]   product_frac_unused;

    function automatic logic [R:0] clamp_duty(input logic [R:0] d);
        return (d > DUTY_MAX) ? DUTY_MAX : d;
    endfunction

    pwm_prescaler #(
        .DVSR_W (DVSR_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .dvsr  (dvsr),
        .tick  (tick)
    );

    assign boundary = tick && (pwm_cnt == CNT_MAX);
    assign accept   = duty_valid && duty_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SCALE0;
            SCALE0:  state_next = SCALE1;
            SCALE1:  state_next = SCALE2;
            SCALE2:  state_next = ARMED;
            ARMED:   if (boundary) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        duty_ready = (state == IDLE);
        commit     = (state == ARMED) && boundary;
    end

    // One multiplier shared across the three SCALE states; gain is brightness+1
    // so full brightness passes a duty of 2**R through unchanged.
    always_comb begin
        mul_in = stage[CH_RED];
        case (state)
            SCALE1:  mul_in = stage[CH_BLUE];
            SCALE2:  mul_in = stage[CH_GREEN];
            default: mul_in = stage[CH_RED];
        endcase
    end

    assign gain    = {1'b0, bright_q} + (R+1)'(1);
    assign product = (2*R+1)'(mul_in) * (2*R+1)'(gain);
    assign {scaled, product_frac_unused} = product;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < 3; ch++) begin
                stage[ch]  <= '0;
                shadow[ch] <= '0;
            end
            bright_q <= '0;
        end else begin
            if (accept) begin
                for (int ch = 0; ch < 3; ch++) begin
                    stage[ch] <= clamp_duty(duty_in[ch*(R+1) +: (R+1)]);
                end
                bright_q <= brightness;
            end
            case (state)
                SCALE0:  shadow[CH_RED]   <= scaled;
                SCALE1:  shadow[CH_BLUE]  <= scaled;
                SCALE2:  shadow[CH_GREEN] <= scaled;
                default: ;
            endcase
        end
    end

    // Active duties change on the same edge that wraps pwm_cnt to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < 3; ch++) begin
                active[ch] <= '0;
            end
        end else if (commit) begin
            for (int ch = 0; ch < 3; ch++) begin
                active[ch] <= shadow[ch];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt <= '0;
            rgb     <= 3'b000;
        end else begin
            if (tick) begin
                pwm_cnt <= pwm_cnt + R'(1);
            end
            for (int ch = 0; ch < 3; ch++) begin
                rgb[ch] <= ({1'b0, pwm_cnt} < active[ch]);
            end
        end
    end

endmodule
